// File: rtl/inst_fetch_axi_bridge.sv
// inst_fetch_axi_bridge: single-beat AXI4 read bridge for the core's instruction fetch port
module inst_fetch_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  inst_req_valid,
  output logic                  inst_req_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [ADDR_WIDTH-1:0] cpu_inst_araddr,
  output logic                  cpu_inst_arvalid,
  input  logic                  cpu_inst_arready,
  output logic [2:0]            cpu_inst_arsize,
  output logic [1:0]            cpu_inst_arburst,
  output logic [7:0]            cpu_inst_arlen,
  input  logic [DATA_WIDTH-1:0] cpu_inst_rdata,
  input  logic [1:0]            cpu_inst_rresp,
  input  logic                  cpu_inst_rlast,
  input  logic                  cpu_inst_rvalid,
  output logic                  cpu_inst_rready,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
);
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
  state_t                state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  err_q, err_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    inst_d      = inst_q;
    err_d       = err_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q + {31'd0, state_q == AR || state_q == R};
    case (state_q)
      IDLE: if (inst_req_valid) begin
        araddr_d = {pc[ADDR_WIDTH-1:2], 2'b00};
        state_d  = AR;
      end
      AR: if (cpu_inst_arready) state_d = R;
      // Extra beats overwrite the capture; only rlast ends the read.
      R: if (cpu_inst_rvalid) begin
        inst_d = cpu_inst_rdata;
        err_d  = cpu_inst_rresp != 2'b00;
        if (cpu_inst_rlast) state_d = RESP;
      end
      RESP: if (inst_ready) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arvalid_d = state_d == AR;
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      inst_q      <= '0;
      err_q       <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      inst_q      <= inst_d;
      err_q       <= err_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign inst_req_ready   = state_q == IDLE;
  assign cpu_inst_arvalid = arvalid_q;
  assign cpu_inst_araddr  = araddr_q;
  assign cpu_inst_rready  = state_q == R;
  assign inst_valid       = state_q == RESP;
  assign inst             = inst_q;
  assign inst_err         = err_q;
  assign cpu_inst_arsize  = 3'b010;
  assign cpu_inst_arburst = 2'b01;
  assign cpu_inst_arlen   = 8'd0;
  assign fetch_cnt        = fetch_cnt_q;
  assign stall_cnt        = stall_cnt_q;
endmodule

// File: tb/tb_inst_fetch_axi_bridge.sv
// tb_inst_fetch_axi_bridge: directed fetches checked against a transaction-level model every cycle
module tb_inst_fetch_axi_bridge;
  logic        clk = 0, rst = 1;
  logic [31:0] pc = 0, rdata = 0;
  logic        req_valid = 0, inst_ready = 0, arready = 0, rvalid = 0, rlast = 0;
  logic [1:0]  rresp = 0;
  logic        req_ready, inst_err, inst_valid, arvalid, rready;
  logic [31:0] inst, araddr, fetch_cnt, stall_cnt;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  int          checks = 0, failures = 0;
  logic [31:0] stall_ofs = 0;

  inst_fetch_axi_bridge dut (
    .cpu_clk(clk), .cpu_reset(rst), .pc(pc), .inst_req_valid(req_valid),
    .inst_req_ready(req_ready), .inst(inst), .inst_err(inst_err), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .cpu_inst_araddr(araddr), .cpu_inst_arvalid(arvalid),
    .cpu_inst_arready(arready), .cpu_inst_arsize(arsize), .cpu_inst_arburst(arburst),
    .cpu_inst_arlen(arlen), .cpu_inst_rdata(rdata), .cpu_inst_rresp(rresp),
    .cpu_inst_rlast(rlast), .cpu_inst_rvalid(rvalid), .cpu_inst_rready(rready),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Transaction model: a fetch is outstanding, its address has been sent, its data has come back
  logic        m_busy = 0, m_sent = 0, m_got = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_inst = 0, m_fetch = 0, m_stall = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_sent <= 0; m_got <= 0; m_err <= 0;
      m_addr <= 0; m_inst <= 0; m_fetch <= 0; m_stall <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1;
        m_addr <= {pc[31:2], 2'b00};
      end
    end else if (!m_sent) begin
      m_stall <= m_stall + 1;
      if (arready) m_sent <= 1;
    end else if (!m_got) begin
      m_stall <= m_stall + 1;
      if (rvalid) begin
        m_inst <= rdata;
        m_err  <= rresp != 2'b00;
        if (rlast) m_got <= 1;
      end
    end else if (inst_ready) begin
      m_fetch <= m_fetch + 1;
      m_busy <= 0; m_sent <= 0; m_got <= 0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
    chk("arvalid", {31'd0, arvalid}, {31'd0, m_busy && !m_sent});
    chk("rready", {31'd0, rready}, {31'd0, m_busy && m_sent && !m_got});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_got});
    chk("araddr", araddr, m_addr);
    chk("inst", inst, m_inst);
    chk("inst_err", {31'd0, inst_err}, {31'd0, m_err});
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("stall_cnt", stall_cnt, m_stall + stall_ofs);
    chk("ar_consts", {19'd0, arsize, arburst, arlen}, {19'd0, 3'b010, 2'b01, 8'd0});
  end

  task automatic fetch(input logic [31:0] p, input int ard, input logic [31:0] d,
                       input logic [1:0] rr, input int hold, input logic [31:0] ea, input logic ee);
    @(posedge clk) #1; pc = p; req_valid = 1;
    @(posedge clk) #1; req_valid = 0;
    @(negedge clk);
    chk("lit_araddr", araddr, ea);
    chk("lit_arvalid", {31'd0, arvalid}, 32'd1);
    repeat (ard) @(negedge clk);
    arready = 1;
    @(posedge clk) #1; arready = 0; rvalid = 1; rlast = 1; rdata = d; rresp = rr;
    @(posedge clk) #1; rvalid = 0; rlast = 0; rresp = 2'b11; rdata = 32'h0BAD_0BAD;
    inst_ready = hold == 0; req_valid = hold != 0;
    @(negedge clk);
    chk("lit_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("lit_inst", inst, d);
    chk("lit_inst_err", {31'd0, inst_err}, {31'd0, ee});
    if (hold != 0) begin
      repeat (hold) @(posedge clk);
      #1; inst_ready = 1; req_valid = 0;
    end
    @(posedge clk) #1; inst_ready = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    fetch(32'h0000_0104, 0, 32'h2402_0005, 2'b00, 0, 32'h0000_0104, 0);
    chk("t1_fetch_cnt", fetch_cnt, 32'd1);
    chk("t1_stall_cnt", stall_cnt, 32'd2);
    fetch(32'h0000_0013, 5, 32'h1111_2222, 2'b00, 0, 32'h0000_0010, 0);
    chk("t2_stall_cnt", stall_cnt, 32'd9);
    fetch(32'h0000_0200, 0, 32'h3333_4444, 2'b00, 4, 32'h0000_0200, 0);
    chk("t3_fetch_cnt", fetch_cnt, 32'd3);
    chk("t3_stall_cnt", stall_cnt, 32'd11);
    fetch(32'h0000_0300, 1, 32'hDEAD_BEEF, 2'b10, 0, 32'h0000_0300, 1);
    chk("t4_err_inst", inst, 32'hDEAD_BEEF);
    fetch(32'h0000_0305, 0, 32'h0000_0001, 2'b00, 0, 32'h0000_0304, 0);
    chk("t4_ok_err", {31'd0, inst_err}, 32'd0);
    chk("t4_fetch_cnt", fetch_cnt, 32'd5);
    @(posedge clk) #1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    stall_ofs = 32'hFFFF_FFFE - m_stall;
    #1 release dut.stall_cnt_q;
    @(negedge clk);
    chk("wrap_pre", stall_cnt, 32'hFFFF_FFFE);
    fetch(32'h0000_0400, 2, 32'h5555_6666, 2'b00, 0, 32'h0000_0400, 0);
    chk("wrap_post", stall_cnt, 32'd2);
    @(posedge clk) #1; pc = 32'h0000_0500; req_valid = 1;
    @(posedge clk) #1; req_valid = 0; arready = 1;
    @(posedge clk) #1; arready = 0;
    #2; rst = 1; stall_ofs = 0;
    #1;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    @(posedge clk) #1; rst = 0;
    fetch(32'h0000_0104, 0, 32'h2402_0005, 2'b00, 0, 32'h0000_0104, 0);
    chk("t5_fetch_cnt", fetch_cnt, 32'd1);
    chk("t5_stall_cnt", stall_cnt, 32'd2);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
